spi_image_loader: RTL and testbench

Consumes the byte stream from the SPI peripheral (`rx_byte`/`byte_valid`) and assembles one packed binary input image for the BNN core. A small command protocol drives it: a start command, then the packed pixel bytes. It holds the finished image stable with a valid/ack handshake until the inference engine takes it. It sits between the SPI front end and the BNN input layer.

---
 rtl/bnn_img_pkg.sv | 20 ++
 rtl/spi_image_loader.sv | 162 ++++++++++++++++
 tb/tb_spi_image_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_img_pkg.sv
// Shared constants and state encoding for the SPI image loader.
// Optional checksum stage is enabled by defining SPI_IMG_CHECKSUM_EN.
package bnn_img_pkg;

  localparam logic [7:0] CMD_START = 8'hC1;
  localparam logic [7:0] CMD_CLEAR = 8'hC2;

  localparam int unsigned IMG_BITS  = 900;
  localparam int unsigned IMG_BYTES = (IMG_BITS + 7) / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef SPI_IMG_CHECKSUM_EN
    ST_CHECK = 2'd2,
`endif
    ST_FULL  = 2'd3
  } img_load_state_t;

endpackage

// File: rtl/spi_image_loader.sv
// Assembles one packed binary image from the SPI byte stream and holds it
// for the BNN core with a valid/ack handshake. Macro: SPI_IMG_CHECKSUM_EN.
//
// state    | meaning
// ST_IDLE  | waiting for CMD_START; CMD_CLEAR clears the sticky flags
// ST_LOAD  | every byte is image data, placed MSB-first
// ST_CHECK | next byte is compared with the XOR of the data bytes
// ST_FULL  | image complete and frozen until ack or CMD_CLEAR
module spi_image_loader
  import bnn_img_pkg::*;
#(
  parameter int unsigned IMG_BITS = bnn_img_pkg::IMG_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                byte_valid,
  input  logic                img_ack,
  output logic [IMG_BITS-1:0] img_bits,
  output logic                img_valid,
  output logic                busy,
  output logic [6:0]          byte_count,
  output logic                overrun,
  output logic                cksum_err
);

  localparam int unsigned IMG_BYTES = (IMG_BITS + 7) / 8;
  localparam int unsigned LAST_W    = IMG_BITS - 8 * (IMG_BYTES - 1);
  localparam int unsigned IDX_W     = $clog2(IMG_BITS);
  localparam logic [6:0]  LAST_IDX  = 7'(IMG_BYTES - 1);

  img_load_state_t     state_q;
  logic [IMG_BITS-1:0] img_q;
  logic [IMG_BITS-1:0] img_d;
  logic [6:0]          byte_cnt_q;
  logic                valid_q;
  logic                busy_q;
  logic                overrun_q;
  logic [IDX_W-1:0]    base_idx;
`ifdef SPI_IMG_CHECKSUM_EN
  logic [7:0]          cksum_q;
  logic                cksum_err_q;
`endif

  // Base index is only formed for full bytes, so it can never underflow.
  always_comb begin
    img_d    = img_q;
    base_idx = '0;
    if (byte_cnt_q < LAST_IDX) begin
      base_idx = IDX_W'(IMG_BITS - 1 - (32'(byte_cnt_q) << 3));
    end
    if (byte_cnt_q == LAST_IDX) begin
      img_d[LAST_W-1:0] = rx_byte[7 -: LAST_W];
    end else begin
      img_d[base_idx -: 8] = rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      img_q       <= '0;
      byte_cnt_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SPI_IMG_CHECKSUM_EN
      cksum_q     <= '0;
      cksum_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_valid) begin
            if (rx_byte == CMD_START) begin
              img_q      <= '0;
              byte_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= ST_LOAD;
`ifdef SPI_IMG_CHECKSUM_EN
              cksum_q    <= '0;
`endif
            end else if (rx_byte == CMD_CLEAR) begin
              overrun_q   <= 1'b0;
`ifdef SPI_IMG_CHECKSUM_EN
              cksum_err_q <= 1'b0;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (byte_valid) begin
            img_q      <= img_d;
            byte_cnt_q <= byte_cnt_q + 7'd1;
`ifdef SPI_IMG_CHECKSUM_EN
            cksum_q    <= cksum_q ^ rx_byte;
`endif
            if (byte_cnt_q == LAST_IDX) begin
`ifdef SPI_IMG_CHECKSUM_EN
              state_q <= ST_CHECK;
`else
              state_q <= ST_FULL;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
`endif
            end
          end
        end
`ifdef SPI_IMG_CHECKSUM_EN
        ST_CHECK: begin
          if (byte_valid) begin
            busy_q <= 1'b0;
            if (rx_byte == cksum_q) begin
              state_q <= ST_FULL;
              valid_q <= 1'b1;
            end else begin
              cksum_err_q <= 1'b1;
              img_q       <= '0;
              state_q     <= ST_IDLE;
            end
          end
        end
`endif
        ST_FULL: begin
          // Ack has priority; a coincident byte is dropped but still flags overrun.
          if (img_ack) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
            if (byte_valid && (rx_byte != CMD_CLEAR)) begin
              overrun_q <= 1'b1;
            end
          end else if (byte_valid) begin
            if (rx_byte == CMD_CLEAR) begin
              img_q       <= '0;
              valid_q     <= 1'b0;
              state_q     <= ST_IDLE;
              overrun_q   <= 1'b0;
`ifdef SPI_IMG_CHECKSUM_EN
              cksum_err_q <= 1'b0;
`endif
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign img_bits   = img_q;
  assign img_valid  = valid_q;
  assign busy       = busy_q;
  assign byte_count = byte_cnt_q;
  assign overrun    = overrun_q;
`ifdef SPI_IMG_CHECKSUM_EN
  assign cksum_err  = cksum_err_q;
`else
  assign cksum_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_image_loader.sv
// Scoreboard bench for spi_image_loader: stimulus queues expected snapshots
// and images, monitors pop and compare. Honours SPI_IMG_CHECKSUM_EN.
module tb_spi_image_loader;
  import bnn_img_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          rx_byte = 8'h00;
  logic                byte_valid = 1'b0;
  logic                img_ack = 1'b0;
  logic [IMG_BITS-1:0] img_bits;
  logic                img_valid;
  logic                busy;
  logic [6:0]          byte_count;
  logic                overrun;
  logic                cksum_err;

  spi_image_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .img_ack    (img_ack),
    .img_bits   (img_bits),
    .img_valid  (img_valid),
    .busy       (busy),
    .byte_count (byte_count),
    .overrun    (overrun),
    .cksum_err  (cksum_err)
  );

  always #5 clk = ~clk;

  localparam logic [IMG_BITS-1:0] IMG_ZERO = '0;
  localparam logic [IMG_BITS-1:0] IMG_FF   = {IMG_BITS{1'b1}};
  localparam logic [IMG_BITS-1:0] IMG_PAD  = {896'b0, 4'hA};
  localparam logic [IMG_BITS-1:0] IMG_3C   = {{112{8'h3C}}, 4'h3};
  localparam logic [IMG_BITS-1:0] IMG_96   = {{112{8'h96}}, 4'h9};
  localparam logic [IMG_BITS-1:0] IMG_01   = {{112{8'h01}}, 4'h0};
  localparam logic [IMG_BITS-1:0] IMG_A5P  = {{50{8'hA5}}, 500'b0};

  typedef struct packed {
    logic                valid;
    logic                busy;
    logic [6:0]          cnt;
    logic                chk_cnt;
    logic                ovr;
    logic                ckerr;
    logic                chk_img;
    logic [IMG_BITS-1:0] img;
  } snap_t;

  snap_t               snap_q[$];
  string               name_q[$];
  logic [IMG_BITS-1:0] img_exp_q[$];
  int                  n_chk  = 0;
  int                  n_pass = 0;
  logic                chk_req = 1'b0;
  logic                prev_valid = 1'b0;
  snap_t               s_cur;
  string               nm_cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_img(input string nm, input logic [IMG_BITS-1:0] act,
                         input logic [IMG_BITS-1:0] exp);
    int fd;
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      fd = -1;
      for (int i = IMG_BITS - 1; i >= 0; i--) begin
        if (act[i] !== exp[i]) begin
          fd = i;
          break;
        end
      end
      $display("FAIL %s: got %0d one-bits expected %0d one-bits, first differing bit %0d",
               nm, $countones(act), $countones(exp), fd);
    end
  endtask

  // Snapshot monitor
  always @(negedge clk) begin
    if (chk_req) begin
      if (snap_q.size() == 0) begin
        chk("snap_underflow", 32'd1, 32'd0);
      end else begin
        s_cur  = snap_q.pop_front();
        nm_cur = name_q.pop_front();
        chk({nm_cur, ".valid"}, 32'(img_valid), 32'(s_cur.valid));
        chk({nm_cur, ".busy"}, 32'(busy), 32'(s_cur.busy));
        if (s_cur.chk_cnt) chk({nm_cur, ".count"}, 32'(byte_count), 32'(s_cur.cnt));
        chk({nm_cur, ".overrun"}, 32'(overrun), 32'(s_cur.ovr));
        chk({nm_cur, ".cksum_err"}, 32'(cksum_err), 32'(s_cur.ckerr));
        if (s_cur.chk_img) chk_img({nm_cur, ".img"}, img_bits, s_cur.img);
      end
    end
  end

  // Image monitor: every rising img_valid must match the next queued image
  always @(negedge clk) begin
    if (img_valid && !prev_valid) begin
      if (img_exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else chk_img("img_on_valid", img_bits, img_exp_q.pop_front());
    end
    prev_valid = img_valid;
  end

  task automatic expect_state(input string nm, input logic v, input logic b,
                              input logic [6:0] c, input logic cc, input logic o,
                              input logic ce, input logic ci,
                              input logic [IMG_BITS-1:0] im);
    snap_t s;
    s.valid = v;  s.busy = b;  s.cnt = c;  s.chk_cnt = cc;
    s.ovr = o;    s.ckerr = ce; s.chk_img = ci; s.img = im;
    snap_q.push_back(s);
    name_q.push_back(nm);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte    = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fill, input logic [7:0] last,
                            input logic [7:0] ck, input logic push,
                            input logic [IMG_BITS-1:0] exp_img);
    for (int k = 0; k < 112; k++) send(fill);
    if (push) img_exp_q.push_back(exp_img);
    send(last);
`ifdef SPI_IMG_CHECKSUM_EN
    send(ck);
`else
    if (ck == 8'h00) rx_byte = 8'h00;
`endif
  endtask

  task automatic do_ack();
    img_ack = 1'b1;
    @(posedge clk); #1;
    img_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_state("rst_hold", 0, 0, 7'd0, 1, 0, 0, 1, IMG_ZERO);
    rst = 1'b1;
    expect_state("post_rst", 0, 0, 7'd0, 1, 0, 0, 1, IMG_ZERO);

    // Non-command bytes in IDLE are ignored
    send(8'h00);
    send(8'h55);
    expect_state("idle_junk", 0, 0, 7'd0, 1, 0, 0, 1, IMG_ZERO);

    // Normal load of all-ones
    send(CMD_START);
    expect_state("start", 0, 1, 7'd0, 1, 0, 0, 1, IMG_ZERO);
    send_frame(8'hFF, 8'hFF, 8'hFF, 1, IMG_FF);
    expect_state("full_ff", 1, 0, 7'd113, 1, 0, 0, 1, IMG_FF);

    // Overrun in FULL keeps the image, ack drops valid, clear resets the flag
    send(8'h55);
    expect_state("ovr_set", 1, 0, 7'd113, 1, 1, 0, 1, IMG_FF);
    do_ack();
    expect_state("ack_drop", 0, 0, 7'd0, 0, 1, 0, 0, IMG_ZERO);
    send(CMD_CLEAR);
    expect_state("clr_ovr", 0, 0, 7'd0, 0, 0, 0, 0, IMG_ZERO);

    // Padding nibble of the last byte is discarded
    send(CMD_START);
    send_frame(8'h00, 8'hAF, 8'hAF, 1, IMG_PAD);
    expect_state("pad", 1, 0, 7'd113, 1, 0, 0, 1, IMG_PAD);
    send(CMD_CLEAR);
    expect_state("full_clr", 0, 0, 7'd0, 0, 0, 0, 0, IMG_ZERO);

    // Ack and byte together: ack wins, byte flags overrun
    send(CMD_START);
    send_frame(8'h3C, 8'h3C, 8'h3C, 1, IMG_3C);
    expect_state("full_3c", 1, 0, 7'd113, 1, 0, 0, 1, IMG_3C);
    img_ack    = 1'b1;
    rx_byte    = 8'h12;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    img_ack    = 1'b0;
    byte_valid = 1'b0;
    expect_state("ack_byte", 0, 0, 7'd0, 0, 1, 0, 0, IMG_ZERO);
    send(CMD_START);
    expect_state("restart", 0, 1, 7'd0, 1, 1, 0, 1, IMG_ZERO);
    send_frame(8'h96, 8'h96, 8'h96, 1, IMG_96);
    expect_state("full_96", 1, 0, 7'd113, 1, 1, 0, 1, IMG_96);
    do_ack();

    // Reset in the middle of a load discards the partial image
    send(CMD_CLEAR);
    send(CMD_START);
    for (int k = 0; k < 50; k++) send(8'hA5);
    expect_state("part50", 0, 1, 7'd50, 1, 0, 0, 1, IMG_A5P);
    rst = 1'b0;
    #1;
    expect_state("mid_rst", 0, 0, 7'd0, 1, 0, 0, 1, IMG_ZERO);
    rst = 1'b1;
    expect_state("rst_idle", 0, 0, 7'd0, 1, 0, 0, 1, IMG_ZERO);
    send(CMD_START);
    send_frame(8'h96, 8'h96, 8'h96, 1, IMG_96);
    expect_state("reload_96", 1, 0, 7'd113, 1, 0, 0, 1, IMG_96);
    do_ack();

`ifdef SPI_IMG_CHECKSUM_EN
    // Matching and mismatching checksum
    send(CMD_START);
    send_frame(8'h01, 8'h01, 8'h01, 1, IMG_01);
    expect_state("ck_good", 1, 0, 7'd113, 1, 0, 0, 1, IMG_01);
    do_ack();
    send(CMD_START);
    send_frame(8'h01, 8'h01, 8'h00, 0, IMG_ZERO);
    expect_state("ck_bad", 0, 0, 7'd0, 0, 0, 1, 1, IMG_ZERO);
    send(CMD_CLEAR);
    expect_state("ck_clr", 0, 0, 7'd0, 0, 0, 0, 0, IMG_ZERO);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("img_queue_left", 32'(img_exp_q.size()), 32'd0);
    chk("snap_queue_left", 32'(snap_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
